fpu_issue_ctrl: RTL and testbench

- Sequences multi-cycle FPU operations issued from the ID stage; sits between ID, the FPU wrapper and the WB register-file write port.
- Keeps a 64-entry scoreboard (X and F banks) of destinations still pending from the FPU, and stalls ID on RAW/WAW hazards or when the FPU is occupied.
- Arbitrates the single register-file write port between normal WB traffic and buffered FPU results.

---
 rtl/core_pkg.sv | 37 +++
 rtl/fpu_result_fifo.sv | 68 ++++++
 rtl/fpu_issue_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the FPU issue controller slice.
//   reg_bank_mux_t    : register bank select (X integer bank / F float bank)
//   fpu_issue_state_t : issue FSM states
//   fpu_wb_entry_t    : one buffered FPU writeback (address, bank, data[, flags])
//   SCOREBOARD_W      : one pending bit per {bank, addr} pair
//   sb_idx()          : maps {bank, addr} to a scoreboard bit index
// Optional macro FPU_ISSUE_FFLAGS_EN adds exception flags to the buffered entry.
package core_pkg;

  typedef enum logic {
    REG_BANK_X = 1'b0,
    REG_BANK_F = 1'b1
  } reg_bank_mux_t;

  typedef enum logic [1:0] {
    FIS_IDLE,
    FIS_REQ,
    FIS_WAIT
  } fpu_issue_state_t;

  localparam int SCOREBOARD_W = 64;

  typedef struct packed {
    logic [4:0]    rd;
    reg_bank_mux_t bank;
    logic [31:0]   data;
`ifdef FPU_ISSUE_FFLAGS_EN
    logic [4:0]    fflags;
`endif
  } fpu_wb_entry_t;

  // F bank occupies the upper 32 bits, X bank the lower 32.
  function automatic logic [5:0] sb_idx(input reg_bank_mux_t bank, input logic [4:0] addr);
    return {bank, addr};
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Small FIFO holding FPU results until the register-file write port is free.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   push_i/entry_i : write one entry (ignored when full)
//   pop_i          : drop the head entry (ignored when empty)
//   head_o         : current head entry (valid when !empty_o)
//   count_o        : number of stored entries
//   empty_o        : no entries stored
module fpu_result_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         push_i,
  input  fpu_wb_entry_t                entry_i,
  input  logic                         pop_i,
  output fpu_wb_entry_t                head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  // Pointers wrap naturally at 2**PTR_W; for DEPTH=1 the second slot is
  // never occupied at the same time as the first because count caps at 1.
  localparam int MEM_D = 1 << PTR_W;

  fpu_wb_entry_t    r_mem [MEM_D];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign w_push = push_i && (r_count != CNT_W'(DEPTH));
  assign w_pop  = pop_i && (r_count != '0);

  // NOTE: the data array has no reset; occupancy is tracked by the reset
  // pointers/count, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= entry_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;
  assign empty_o = (r_count == '0);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: sequences multi-cycle FPU ops from ID, tracks pending
// destinations in a 64-bit X/F scoreboard, stalls ID on hazards/occupancy and
// arbitrates the register-file write port between WB and buffered FPU results.
// Ports:
//   clk_i, rst_n_i                      : clock, asynchronous active-low reset
//   fpu_req_id_i, valid_id_i, flush_i   : ID-stage request / valid / kill
//   rd_*_id_i, rs{1,2,3}_*_id_i         : ID destination and source operands
//   fpu_req_o, fpu_gnt_i                : FPU request handshake
//   fpu_rvalid_i, fpu_result_i          : FPU result pulse and data
//   reg_*_pipe_i                        : normal WB write (has priority)
//   reg_wen_o/waddr_o/wdata_o/wdst_o    : arbitrated register-file write port
//   stall_id_o, fpu_busy_o, timeout_o   : ID stall, FSM busy, sticky timeout
// Optional macro FPU_ISSUE_FFLAGS_EN adds fpu_fflags_i, fflags_clr_i and
// fflags_acc_o (flags accumulated when a result leaves the buffer).
module fpu_issue_ctrl
  import core_pkg::*;
#(
  parameter int          RESULT_BUF_DEPTH = 2,
  parameter int unsigned FPU_TIMEOUT      = 0
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          fpu_req_id_i,
  input  logic [4:0]    rd_addr_id_i,
  input  reg_bank_mux_t rd_dst_bank_id_i,
  input  logic          rd_wen_id_i,
  input  logic [4:0]    rs1_addr_id_i,
  input  reg_bank_mux_t rs1_src_bank_id_i,
  input  logic          rs1_is_used_id_i,
  input  logic [4:0]    rs2_addr_id_i,
  input  reg_bank_mux_t rs2_src_bank_id_i,
  input  logic          rs2_is_used_id_i,
  input  logic [4:0]    rs3_addr_id_i,
  input  reg_bank_mux_t rs3_src_bank_id_i,
  input  logic          rs3_is_used_id_i,
  input  logic          valid_id_i,
  input  logic          flush_i,
  output logic          fpu_req_o,
  input  logic          fpu_gnt_i,
  input  logic          fpu_rvalid_i,
  input  logic [31:0]   fpu_result_i,
  input  logic          reg_wen_pipe_i,
  input  logic [4:0]    reg_waddr_pipe_i,
  input  logic [31:0]   reg_wdata_pipe_i,
  input  reg_bank_mux_t reg_wdst_pipe_i,
  output logic          reg_wen_o,
  output logic [4:0]    reg_waddr_o,
  output logic [31:0]   reg_wdata_o,
  output reg_bank_mux_t reg_wdst_o,
  output logic          stall_id_o,
  output logic          fpu_busy_o,
`ifdef FPU_ISSUE_FFLAGS_EN
  input  logic [4:0]    fpu_fflags_i,
  input  logic          fflags_clr_i,
  output logic [4:0]    fflags_acc_o,
`endif
  output logic          timeout_o
);

  localparam int BUF_CNT_W = $clog2(RESULT_BUF_DEPTH + 1);

  fpu_issue_state_t        r_state;
  logic [SCOREBOARD_W-1:0] r_sb;
  logic [4:0]              r_rd;
  reg_bank_mux_t           r_bank;
  logic                    r_wen;
  logic [31:0]             r_wait_cnt;
  logic                    r_timeout;

  logic                 w_rs_hazard, w_rd_hazard, w_hazard;
  logic                 w_can_issue, w_issue, w_sb_set;
  logic                 w_push, w_pop, w_flush_clr;
  logic                 w_buf_empty;
  logic [BUF_CNT_W-1:0] w_buf_count;
  fpu_wb_entry_t        w_push_entry, w_head;
  logic [5:0]           w_set_idx, w_pop_idx;

  assign w_rs_hazard = (rs1_is_used_id_i && r_sb[sb_idx(rs1_src_bank_id_i, rs1_addr_id_i)])
                    || (rs2_is_used_id_i && r_sb[sb_idx(rs2_src_bank_id_i, rs2_addr_id_i)])
                    || (rs3_is_used_id_i && r_sb[sb_idx(rs3_src_bank_id_i, rs3_addr_id_i)]);
  assign w_rd_hazard = rd_wen_id_i && r_sb[sb_idx(rd_dst_bank_id_i, rd_addr_id_i)];
  assign w_hazard    = (valid_id_i && w_rs_hazard) || w_rd_hazard;

  // Buffer headroom is reserved at issue, so the later push can never overflow.
  assign w_can_issue = (r_state == FIS_IDLE) && !w_hazard && !flush_i
                    && (w_buf_count < BUF_CNT_W'(RESULT_BUF_DEPTH));
  assign w_issue     = fpu_req_id_i && w_can_issue;

  // x0 is hardwired, so it is never marked pending.
  assign w_set_idx   = sb_idx(rd_dst_bank_id_i, rd_addr_id_i);
  assign w_sb_set    = w_issue && rd_wen_id_i
                    && !(rd_dst_bank_id_i == REG_BANK_X && rd_addr_id_i == 5'd0);
  assign w_flush_clr = (r_state == FIS_REQ) && flush_i && !fpu_gnt_i && r_wen;
  assign w_push      = (r_state == FIS_WAIT) && fpu_rvalid_i && r_wen;
  assign w_pop       = !reg_wen_pipe_i && !w_buf_empty;
  assign w_pop_idx   = sb_idx(w_head.bank, w_head.rd);

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.rd   = r_rd;
    w_push_entry.bank = r_bank;
    w_push_entry.data = fpu_result_i;
`ifdef FPU_ISSUE_FFLAGS_EN
    w_push_entry.fflags = fpu_fflags_i;
`endif
  end

  fpu_result_fifo #(
    .DEPTH (RESULT_BUF_DEPTH)
  ) u_result_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (w_push),
    .entry_i (w_push_entry),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .count_o (w_buf_count),
    .empty_o (w_buf_empty)
  );

  // Pending bits: cleared when the result is written, or when a flushed
  // request never reached the FPU; set at issue.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sb <= '0;
    end else begin
      if (w_pop)       r_sb[w_pop_idx]              <= 1'b0;
      if (w_flush_clr) r_sb[sb_idx(r_bank, r_rd)]   <= 1'b0;
      if (w_sb_set)    r_sb[w_set_idx]              <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= FIS_IDLE;
      r_rd       <= '0;
      r_bank     <= REG_BANK_X;
      r_wen      <= 1'b0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      unique case (r_state)
        FIS_IDLE: begin
          if (w_issue) begin
            r_rd    <= rd_addr_id_i;
            r_bank  <= rd_dst_bank_id_i;
            r_wen   <= rd_wen_id_i;
            r_state <= fpu_gnt_i ? FIS_WAIT : FIS_REQ;
          end
        end
        FIS_REQ: begin
          // A grant in the flush cycle means the FPU already owns the op.
          if (fpu_gnt_i)    r_state <= FIS_WAIT;
          else if (flush_i) r_state <= FIS_IDLE;
        end
        FIS_WAIT: begin
          if (fpu_rvalid_i) r_state <= FIS_IDLE;
        end
        default: r_state <= FIS_IDLE;
      endcase

      if (FPU_TIMEOUT != 0 && r_state == FIS_WAIT && !fpu_rvalid_i) begin
        if (r_wait_cnt == 32'(FPU_TIMEOUT - 1)) r_timeout <= 1'b1;
        if (!r_timeout) r_wait_cnt <= r_wait_cnt + 32'd1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign fpu_req_o  = w_issue || (r_state == FIS_REQ);
  assign fpu_busy_o = (r_state != FIS_IDLE);
  assign timeout_o  = r_timeout;
  assign stall_id_o = (valid_id_i && w_hazard)
                   || (fpu_req_id_i && !w_can_issue)
                   || (w_issue && !fpu_gnt_i);

  // NOTE: every output gets a default first so no path through the block
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    reg_wen_o   = 1'b0;
    reg_waddr_o = '0;
    reg_wdata_o = '0;
    reg_wdst_o  = REG_BANK_X;
    if (reg_wen_pipe_i) begin
      reg_wen_o   = 1'b1;
      reg_waddr_o = reg_waddr_pipe_i;
      reg_wdata_o = reg_wdata_pipe_i;
      reg_wdst_o  = reg_wdst_pipe_i;
    end else if (!w_buf_empty) begin
      reg_wen_o   = 1'b1;
      reg_waddr_o = w_head.rd;
      reg_wdata_o = w_head.data;
      reg_wdst_o  = w_head.bank;
    end
  end

`ifdef FPU_ISSUE_FFLAGS_EN
  logic [4:0] r_fflags_acc;

  // Flags become architecturally visible with the result write, not at rvalid.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)          r_fflags_acc <= '0;
    else if (fflags_clr_i) r_fflags_acc <= w_pop ? w_head.fflags : 5'd0;
    else if (w_pop)        r_fflags_acc <= r_fflags_acc | w_head.fflags;
  end

  assign fflags_acc_o = r_fflags_acc;
`endif

  // WAW hazards stall issue, so a register cannot be set and retired together.
  sb_no_set_clr_same: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(w_sb_set && w_pop && (w_set_idx == w_pop_idx)));

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl (RESULT_BUF_DEPTH=1, FPU_TIMEOUT=8).
// Expected write-port transactions are queued as stimulus is applied; a
// separate monitor compares every write the DUT presents against the queue.
module tb_fpu_issue_ctrl;
  import core_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          fpu_req_id_i, rd_wen_id_i, valid_id_i, flush_i;
  logic [4:0]    rd_addr_id_i;
  reg_bank_mux_t rd_dst_bank_id_i;
  logic [4:0]    rs1_addr_id_i, rs2_addr_id_i, rs3_addr_id_i;
  reg_bank_mux_t rs1_src_bank_id_i, rs2_src_bank_id_i, rs3_src_bank_id_i;
  logic          rs1_is_used_id_i, rs2_is_used_id_i, rs3_is_used_id_i;
  logic          fpu_req_o, fpu_gnt_i, fpu_rvalid_i;
  logic [31:0]   fpu_result_i;
  logic          reg_wen_pipe_i;
  logic [4:0]    reg_waddr_pipe_i;
  logic [31:0]   reg_wdata_pipe_i;
  reg_bank_mux_t reg_wdst_pipe_i;
  logic          reg_wen_o;
  logic [4:0]    reg_waddr_o;
  logic [31:0]   reg_wdata_o;
  reg_bank_mux_t reg_wdst_o;
  logic          stall_id_o, fpu_busy_o, timeout_o;
`ifdef FPU_ISSUE_FFLAGS_EN
  logic [4:0]    fpu_fflags_i = '0;
  logic          fflags_clr_i = 1'b0;
  logic [4:0]    fflags_acc_o;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [37:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  fpu_issue_ctrl #(
    .RESULT_BUF_DEPTH (1),
    .FPU_TIMEOUT      (8)
  ) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .fpu_req_id_i      (fpu_req_id_i),
    .rd_addr_id_i      (rd_addr_id_i),
    .rd_dst_bank_id_i  (rd_dst_bank_id_i),
    .rd_wen_id_i       (rd_wen_id_i),
    .rs1_addr_id_i     (rs1_addr_id_i),
    .rs1_src_bank_id_i (rs1_src_bank_id_i),
    .rs1_is_used_id_i  (rs1_is_used_id_i),
    .rs2_addr_id_i     (rs2_addr_id_i),
    .rs2_src_bank_id_i (rs2_src_bank_id_i),
    .rs2_is_used_id_i  (rs2_is_used_id_i),
    .rs3_addr_id_i     (rs3_addr_id_i),
    .rs3_src_bank_id_i (rs3_src_bank_id_i),
    .rs3_is_used_id_i  (rs3_is_used_id_i),
    .valid_id_i        (valid_id_i),
    .flush_i           (flush_i),
    .fpu_req_o         (fpu_req_o),
    .fpu_gnt_i         (fpu_gnt_i),
    .fpu_rvalid_i      (fpu_rvalid_i),
    .fpu_result_i      (fpu_result_i),
    .reg_wen_pipe_i    (reg_wen_pipe_i),
    .reg_waddr_pipe_i  (reg_waddr_pipe_i),
    .reg_wdata_pipe_i  (reg_wdata_pipe_i),
    .reg_wdst_pipe_i   (reg_wdst_pipe_i),
    .reg_wen_o         (reg_wen_o),
    .reg_waddr_o       (reg_waddr_o),
    .reg_wdata_o       (reg_wdata_o),
    .reg_wdst_o        (reg_wdst_o),
    .stall_id_o        (stall_id_o),
    .fpu_busy_o        (fpu_busy_o),
`ifdef FPU_ISSUE_FFLAGS_EN
    .fpu_fflags_i      (fpu_fflags_i),
    .fflags_clr_i      (fflags_clr_i),
    .fflags_acc_o      (fflags_acc_o),
`endif
    .timeout_o         (timeout_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({fpu_req_o, stall_id_o, fpu_busy_o, timeout_o,
                reg_wen_o, reg_waddr_o, reg_wdata_o, reg_wdst_o});
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    fpu_req_id_i      = 1'b0;  valid_id_i = 1'b0;  flush_i = 1'b0;
    rd_addr_id_i      = '0;    rd_dst_bank_id_i = REG_BANK_X;  rd_wen_id_i = 1'b0;
    rs1_addr_id_i     = '0;    rs2_addr_id_i = '0;  rs3_addr_id_i = '0;
    rs1_src_bank_id_i = REG_BANK_X;  rs2_src_bank_id_i = REG_BANK_X;
    rs3_src_bank_id_i = REG_BANK_X;
    rs1_is_used_id_i  = 1'b0;  rs2_is_used_id_i = 1'b0;  rs3_is_used_id_i = 1'b0;
    fpu_gnt_i         = 1'b0;  fpu_rvalid_i = 1'b0;  fpu_result_i = '0;
    reg_wen_pipe_i    = 1'b0;  reg_waddr_pipe_i = '0;  reg_wdata_pipe_i = '0;
    reg_wdst_pipe_i   = REG_BANK_X;
  endtask

  // FPU instruction in ID writing rd, no sources.
  task automatic set_id_fpu(input logic [4:0] rd, input reg_bank_mux_t bank);
    fpu_req_id_i = 1'b1;  valid_id_i = 1'b1;
    rd_addr_id_i = rd;    rd_dst_bank_id_i = bank;  rd_wen_id_i = 1'b1;
  endtask

  // Non-FPU instruction in ID reading one source.
  task automatic set_id_read(input logic [4:0] rs, input reg_bank_mux_t bank);
    valid_id_i = 1'b1;  rs1_addr_id_i = rs;  rs1_src_bank_id_i = bank;
    rs1_is_used_id_i = 1'b1;
  endtask

  // Monitor: every write presented on the port must match the next expected one.
  initial begin
    logic [37:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_n_i === 1'b1 && reg_wen_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 64'(reg_wen_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wb_port", 64'({reg_waddr_o, reg_wdst_o, reg_wdata_o}), 64'(e));
        end
      end
    end
  end

  initial begin
    drive_idle();
    rst_n_i = 1'b0;
    repeat (2) cyc();
    @(negedge clk_i);
    check("reset_outputs", all_outs(), 64'd0);
    rst_n_i = 1'b1;
    cyc();

    // f5 issued with same-cycle grant; result returns in the 4th WAIT cycle.
    set_id_fpu(5'd5, REG_BANK_F);
    fpu_gnt_i = 1'b1;
    @(negedge clk_i);
    check("t1_req_same_cycle", 64'(fpu_req_o), 64'd1);
    check("t1_no_stall_on_gnt", 64'(stall_id_o), 64'd0);
    cyc();
    drive_idle();
    set_id_read(5'd5, REG_BANK_F);
    for (int c = 1; c <= 5; c++) begin
      if (c == 4) begin
        fpu_rvalid_i = 1'b1;
        fpu_result_i = 32'h40a0_0000;
        exp_q.push_back({5'd5, REG_BANK_F, 32'h40a0_0000});
      end
      @(negedge clk_i);
      check("t1_stall_pending", 64'(stall_id_o), 64'd1);
      if (c == 1) check("t1_busy", 64'(fpu_busy_o), 64'd1);
      if (c == 4) check("t1_no_wb_at_rvalid", 64'(reg_wen_o), 64'd0);
      if (c == 5) check("t1_wb_next_cycle", 64'(reg_wen_o), 64'd1);
      cyc();
      fpu_rvalid_i = 1'b0;
    end
    @(negedge clk_i);
    check("t1_stall_released", 64'(stall_id_o), 64'd0);
    cyc();
    drive_idle();

    // x0 destination: never marked pending, result still written.
    set_id_fpu(5'd0, REG_BANK_X);
    fpu_gnt_i = 1'b1;
    @(negedge clk_i);
    check("x0_issue_req", 64'(fpu_req_o), 64'd1);
    cyc();
    drive_idle();
    valid_id_i = 1'b1;  rd_wen_id_i = 1'b1;  rd_addr_id_i = 5'd0;
    set_id_read(5'd0, REG_BANK_X);
    @(negedge clk_i);
    check("x0_never_stalls", 64'(stall_id_o), 64'd0);
    cyc();
    drive_idle();
    fpu_rvalid_i = 1'b1;
    fpu_result_i = 32'h1234_5678;
    exp_q.push_back({5'd0, REG_BANK_X, 32'h1234_5678});
    cyc();
    drive_idle();
    @(negedge clk_i);
    check("x0_wb", 64'(reg_wen_o), 64'd1);
    cyc();

    // Grant arrives in the third request cycle.
    set_id_fpu(5'd7, REG_BANK_F);
    for (int c = 0; c < 3; c++) begin
      fpu_gnt_i = (c == 2);
      @(negedge clk_i);
      check("t2_req_held", 64'(fpu_req_o), 64'd1);
      check("t2_stall_held", 64'(stall_id_o), 64'd1);
      cyc();
    end
    drive_idle();
    fpu_rvalid_i = 1'b1;
    fpu_result_i = 32'hc0e0_0000;
    exp_q.push_back({5'd7, REG_BANK_F, 32'hc0e0_0000});
    @(negedge clk_i);
    check("t2_req_dropped", 64'(fpu_req_o), 64'd0);
    cyc();
    drive_idle();
    @(negedge clk_i);
    check("t2_wb", 64'(reg_wen_o), 64'd1);
    cyc();

    // Flush while waiting for grant: op dropped, f9 no longer pending.
    set_id_fpu(5'd9, REG_BANK_F);
    @(negedge clk_i);
    check("t3_req", 64'(fpu_req_o), 64'd1);
    cyc();
    flush_i = 1'b1;
    @(negedge clk_i);
    check("t3_busy_in_req", 64'(fpu_busy_o), 64'd1);
    cyc();
    drive_idle();
    set_id_read(5'd9, REG_BANK_F);
    @(negedge clk_i);
    check("t3_idle_after_flush", 64'(fpu_busy_o), 64'd0);
    check("t3_sb_cleared", 64'(stall_id_o), 64'd0);
    cyc();

    // Flush and grant together: grant wins, result written.
    drive_idle();
    set_id_fpu(5'd10, REG_BANK_F);
    @(negedge clk_i);
    cyc();
    flush_i = 1'b1;
    fpu_gnt_i = 1'b1;
    @(negedge clk_i);
    cyc();
    drive_idle();
    fpu_rvalid_i = 1'b1;
    fpu_result_i = 32'h3f80_0000;
    exp_q.push_back({5'd10, REG_BANK_F, 32'h3f80_0000});
    @(negedge clk_i);
    check("t3b_busy_wait", 64'(fpu_busy_o), 64'd1);
    cyc();
    drive_idle();
    @(negedge clk_i);
    check("t3b_wb", 64'(reg_wen_o), 64'd1);
    cyc();

    // rvalid while WB owns the port for 3 cycles; buffer (depth 1) then blocks issue.
    set_id_fpu(5'd12, REG_BANK_F);
    fpu_gnt_i = 1'b1;
    @(negedge clk_i);
    cyc();
    drive_idle();
    for (int c = 1; c <= 3; c++) begin
      fpu_rvalid_i     = (c == 1);
      fpu_result_i     = 32'h4120_0000;
      reg_wen_pipe_i   = 1'b1;
      reg_waddr_pipe_i = 5'd3;
      reg_wdst_pipe_i  = REG_BANK_X;
      reg_wdata_pipe_i = 32'h0000_0a00 + 32'(c);
      exp_q.push_back({5'd3, REG_BANK_X, 32'h0000_0a00 + 32'(c)});
      if (c >= 2) begin
        set_id_fpu(5'd13, REG_BANK_F);
        fpu_gnt_i = 1'b1;
      end
      @(negedge clk_i);
      if (c >= 2) begin
        check("t4_buf_full_stall", 64'(stall_id_o), 64'd1);
        check("t4_buf_full_noreq", 64'(fpu_req_o), 64'd0);
      end
      cyc();
    end
    exp_q.push_back({5'd12, REG_BANK_F, 32'h4120_0000});
    fpu_rvalid_i   = 1'b0;
    reg_wen_pipe_i = 1'b0;
    @(negedge clk_i);
    check("t4_fpu_wb_cycle4", 64'(reg_waddr_o), 64'd12);
    check("t4_still_blocked", 64'(stall_id_o), 64'd1);
    cyc();
    @(negedge clk_i);
    check("t4_issue_after_drain", 64'(fpu_req_o), 64'd1);
    check("t4_no_stall_on_gnt", 64'(stall_id_o), 64'd0);
    cyc();

    // f13 never returns: timeout after 8 WAIT cycles.
    drive_idle();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      check("to_not_yet", 64'(timeout_o), 64'd0);
      cyc();
    end
    set_id_read(5'd13, REG_BANK_F);
    @(negedge clk_i);
    check("to_set", 64'(timeout_o), 64'd1);
    check("to_pending_stall", 64'(stall_id_o), 64'd1);

    // Reset in the middle of WAIT.
    #1 rst_n_i = 1'b0;
    #1 check("reset_mid_wait", all_outs(), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cyc();
    fpu_rvalid_i = 1'b1;
    fpu_result_i = 32'hdead_beef;
    @(negedge clk_i);
    check("post_reset_idle", 64'(fpu_busy_o), 64'd0);
    check("post_reset_sb_empty", 64'(stall_id_o), 64'd0);
    check("post_reset_timeout", 64'(timeout_o), 64'd0);
    cyc();
    drive_idle();
    @(negedge clk_i);
    check("stale_rvalid_dropped", 64'(reg_wen_o), 64'd0);
    cyc();

    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
